// File: rtl/hash_cmd_queue_if.sv
// Handshake bundle between the producer, the command queue and the hash block.
// The queue uses the slave modport; the producer/hash-block side uses master.
interface hash_cmd_queue_if #(
    parameter int num_size = 10,
    parameter int ptr_bits = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_mode;
    logic [num_size-1:0] in_num;
    logic [1:0]          mode;
    logic [num_size-1:0] num;
    logic                cmplt;
    logic                busy;
    logic [ptr_bits:0]   count;
    logic                err;

    modport slave (
        input  in_valid, in_mode, in_num, cmplt,
        output in_ready, mode, num, busy, count, err
    );

    modport master (
        output in_valid, in_mode, in_num, cmplt,
        input  in_ready, mode, num, busy, count, err
    );
endinterface

// File: rtl/hash_cmd_queue.sv
// Command FIFO in front of the hash block: issues one command at a time as a
// single-cycle mode pulse, waits for cmplt, and aborts with err on timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | nothing in flight; pops the FIFO head when count != 0
// ST_ISSUE | mode pulse cycle; wait timer loaded
// ST_WAIT  | waiting for cmplt; timer expiry aborts with err
module hash_cmd_queue #(
    parameter int num_size = 10,
    parameter int depth    = 4,
    parameter int ptr_bits = 2,
    parameter int timeout  = 64
) (
    input logic            clk,
    input logic            rst,
    hash_cmd_queue_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Down-counter holds the WAIT cycles remaining after the current one.
    localparam int cnt_bits = (timeout > 2) ? $clog2(timeout - 1) : 1;
    localparam logic [cnt_bits-1:0] wait_load = cnt_bits'(timeout - 2);
    localparam logic [ptr_bits:0]   full_cnt  = (ptr_bits + 1)'(depth);

    state_t                state_q, state_d;
    logic [ptr_bits-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_bits-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_bits:0]     count_q, count_d;
    logic [1:0]            mode_q, mode_d;
    logic [num_size-1:0]   num_q, num_d;
    logic                  err_q, err_d;
    logic [cnt_bits-1:0]   wait_q, wait_d;
    logic [num_size+1:0]   fifo_q [depth];
    logic [num_size+1:0]   fifo_d [depth];
    logic                  push;
    logic                  pop;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mode_d   = 2'b00;
        num_d    = num_q;
        err_d    = 1'b0;
        wait_d   = wait_q;
        fifo_d   = fifo_q;
        pop      = 1'b0;
        // A full queue refuses pushes even on a cycle that also pops.
        push     = bus.in_valid && (count_q != full_cnt) && (bus.in_mode != 2'b00);

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop               = 1'b1;
                    {mode_d, num_d}   = fifo_q[rd_ptr_q];
                    rd_ptr_d          = rd_ptr_q + 1'b1;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_d  = wait_load;
                state_d = bus.cmplt ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.cmplt) begin
                    state_d = ST_IDLE;
                end else if (wait_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = {bus.in_mode, bus.in_num};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= 2'b00;
            num_q    <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            fifo_q   <= fifo_d;
        end
    end

    assign bus.in_ready = (count_q != full_cnt);
    assign bus.mode     = mode_q;
    assign bus.num      = num_q;
    assign bus.busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.count    = count_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_hash_cmd_queue.sv
// Bench for hash_cmd_queue: directed vector table, timeout corner sequences,
// and random traffic compared every cycle against a queue-based reference model.
module tb_hash_cmd_queue;
    localparam int NS    = 10;
    localparam int DEPTH = 4;
    localparam int PB    = 2;
    localparam int TO    = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hash_cmd_queue_if #(.num_size(NS), .ptr_bits(PB)) bus ();

    hash_cmd_queue #(.num_size(NS), .depth(DEPTH), .ptr_bits(PB), .timeout(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int err_seen  = 0;

    // Reference model: command queue plus age of the in-flight command
    // (age 0 = issue cycle); abort when a command reaches age TO-1 uncompleted.
    typedef struct packed {
        logic [1:0]    m;
        logic [NS-1:0] n;
    } cmd_t;

    cmd_t          mq[$];
    bit            inflight = 0;
    int            age      = 0;
    logic [1:0]    m_mode   = 2'b00;
    logic [NS-1:0] m_num    = '0;
    bit            m_err    = 0;
    bit            model_ok = 0;

    typedef struct {
        logic          r, v;
        logic [1:0]    m;
        logic [NS-1:0] n;
        logic          c;
        logic [17:0]   exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int r, int v, int m, int n, int c,
                                int cnt, int md, int nm, int b, int e, int rd);
        vec_t x;
        x.r   = 1'(r);
        x.v   = 1'(v);
        x.m   = 2'(m);
        x.n   = NS'(n);
        x.c   = 1'(c);
        x.exp = {3'(cnt), 2'(md), NS'(nm), 1'(b), 1'(e), 1'(rd)};
        return x;
    endfunction

    function automatic logic [17:0] outs();
        return {bus.count, bus.mode, bus.num, bus.busy, bus.err, bus.in_ready};
    endfunction

    function automatic logic [17:0] model_exp();
        return {3'(mq.size()), m_mode, m_num, 1'(inflight), 1'(m_err), 1'(mq.size() != DEPTH)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [1:0] m,
                              input logic [NS-1:0] n, input logic c);
        int   pre;
        cmd_t h;
        if (r) begin
            mq.delete();
            inflight = 0;
            age      = 0;
            m_mode   = 2'b00;
            m_num    = '0;
            m_err    = 0;
            model_ok = 1;
            return;
        end
        pre    = mq.size();
        m_mode = 2'b00;
        m_err  = 0;
        if (inflight) begin
            if (c) inflight = 0;
            else if (age == TO - 1) begin
                inflight = 0;
                m_err    = 1;
            end else age++;
        end else if (pre != 0) begin
            h        = mq.pop_front();
            m_mode   = h.m;
            m_num    = h.n;
            inflight = 1;
            age      = 0;
        end
        if (v && pre != DEPTH && m != 2'b00) mq.push_back(cmd_t'({m, n}));
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] m,
                       input logic [NS-1:0] n, input logic c);
        rst          = r;
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_num   = n;
        bus.cmplt    = c;
        @(posedge clk);
        model_step(r, v, m, n, c);
        @(negedge clk);
        if (model_ok) check("model", 32'(outs()), 32'(model_exp()));
        if (bus.err) err_seen++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        // r v m n c | count mode num busy err ready
        tbl.push_back(mk(1,0,0,  0,0, 0,0,  0,0,0,1));
        tbl.push_back(mk(0,1,1, 23,0, 1,0,  0,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,1, 23,1,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,0, 23,1,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,0, 23,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 0,0, 23,0,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 0,0, 23,0,0,1));
        tbl.push_back(mk(0,1,0, 99,0, 0,0, 23,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,0, 23,0,0,1));
        tbl.push_back(mk(0,1,1,  1,0, 1,0, 23,0,0,1));
        tbl.push_back(mk(0,1,2,  2,0, 1,1,  1,1,0,1));
        tbl.push_back(mk(0,1,3,  3,0, 2,0,  1,1,0,1));
        tbl.push_back(mk(0,1,1,  4,0, 3,0,  1,1,0,1));
        tbl.push_back(mk(0,1,2,  5,0, 4,0,  1,1,0,0));
        tbl.push_back(mk(0,1,3,  6,0, 4,0,  1,1,0,0));
        tbl.push_back(mk(0,0,0,  0,1, 4,0,  1,0,0,0));
        tbl.push_back(mk(0,1,1,  7,0, 3,2,  2,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 3,0,  2,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 2,3,  3,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 2,0,  3,0,0,1));
        tbl.push_back(mk(0,1,1,  8,0, 2,1,  4,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 2,0,  4,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 1,2,  5,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 1,0,  5,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,1,  8,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 0,0,  8,0,0,1));
        tbl.push_back(mk(0,1,2,  5,0, 1,0,  8,0,0,1));
        tbl.push_back(mk(0,1,2, 17,0, 1,2,  5,1,0,1));
        tbl.push_back(mk(0,1,2, 42,1, 2,0,  5,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 1,2, 17,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 1,0, 17,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,2, 42,1,0,1));
        tbl.push_back(mk(0,0,0,  0,1, 0,0, 42,0,0,1));
        tbl.push_back(mk(0,1,1,100,0, 1,0, 42,0,0,1));
        tbl.push_back(mk(0,1,1,101,0, 1,1,100,1,0,1));
        tbl.push_back(mk(0,1,1,102,0, 2,0,100,1,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 2,0,100,1,0,1));
        tbl.push_back(mk(1,0,0,  0,0, 0,0,  0,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0, 0,0,  0,0,0,1));

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].m, tbl[i].n, tbl[i].c);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Timeout: no cmplt; err must appear 64 cycles after the issue cycle.
        cyc(0, 1, 2'd2, NS'(555), 0);
        cyc(0, 1, 2'd3, NS'(556), 0);
        check("to_issue", {30'd0, bus.mode}, 32'd2);
        err_seen = 0;
        k = 0;
        for (int j = 1; j <= 80 && k == 0; j++) begin
            cyc(0, 0, 2'd0, '0, 0);
            if (bus.err) k = j;
        end
        check("to_err_cycle", k, 64);
        cyc(0, 0, 2'd0, '0, 0);
        check("to_next_issue", {20'd0, bus.mode, bus.num}, {20'd0, 2'd3, NS'(556)});
        check("to_err_once", err_seen, 1);
        cyc(0, 0, 2'd0, '0, 1);

        // cmplt on the timeout cycle counts as completion.
        cyc(0, 1, 2'd1, NS'(600), 0);
        cyc(0, 0, 2'd0, '0, 0);
        err_seen = 0;
        for (int j = 0; j < TO - 1; j++) cyc(0, 0, 2'd0, '0, 0);
        cyc(0, 0, 2'd0, '0, 1);
        check("tie_no_err", err_seen, 0);
        check("tie_idle", {31'd0, bus.busy}, 32'd0);

        // Random traffic against the reference model.
        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom_range(0, 399) == 0),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                NS'($urandom_range(0, 1023)),
                ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
